pcs_sync_fsm: RTL

//  1000BASE-X receive synchronization controller (IEEE 802.3 Cl.36 sync FSM) placed after the 8b/10b decoder.

---
 rtl/pcs_sync_fsm_pkg.sv | 29 ++
 rtl/pcs_sync_fsm_comma_det.sv | 25 ++
 rtl/pcs_sync_fsm.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pcs_sync_fsm_pkg.sv
// Shared definitions for the 1000BASE-X receive synchronization controller:
// state encoding, comma patterns and a "link is synced" decode helper.
package pcs_sync_fsm_pkg;

   // Encoding 11 is left unused so that SYNC_ACQUIRED_4A lands on 13.
   typedef enum logic [3:0] {
      LOSS_OF_SYNC     = 4'd0,
      COMMA_DETECT_1   = 4'd1,
      ACQUIRE_SYNC_1   = 4'd2,
      COMMA_DETECT_2   = 4'd3,
      ACQUIRE_SYNC_2   = 4'd4,
      COMMA_DETECT_3   = 4'd5,
      SYNC_ACQUIRED_1  = 4'd6,
      SYNC_ACQUIRED_2  = 4'd7,
      SYNC_ACQUIRED_2A = 4'd8,
      SYNC_ACQUIRED_3  = 4'd9,
      SYNC_ACQUIRED_3A = 4'd10,
      SYNC_ACQUIRED_4  = 4'd12,
      SYNC_ACQUIRED_4A = 4'd13
   } sync_state_e;

   localparam logic [6:0] COMMA_POS = 7'b0011111;
   localparam logic [6:0] COMMA_NEG = 7'b1100000;

   function automatic logic is_synced(input sync_state_e s);
      return (s >= SYNC_ACQUIRED_1);
   endfunction

endpackage

// File: rtl/pcs_sync_fsm_comma_det.sv
// Combinational classifier for one code-group: comma detection and the
// good/bad/data qualifiers used by the sync state machine.
module pcs_sync_fsm_comma_det
   import pcs_sync_fsm_pkg::*;
(
   input  logic [9:0] data_10b,
   input  logic       is_invalid,
   input  logic       control,
   input  logic       odd_pos,
   output logic       comma,
   output logic       cgbad,
   output logic       cggood,
   output logic       cgdata
);

   // Only the abcdefg bits carry the comma; the low bits are don't-care.
   logic unused_low;
   assign unused_low = ^data_10b[2:0];

   assign comma  = (data_10b[9:3] == COMMA_POS) | (data_10b[9:3] == COMMA_NEG);
   assign cgbad  = is_invalid | (comma & odd_pos);
   assign cggood = ~cgbad;
   assign cgdata = ~is_invalid & ~control;

endmodule

// File: rtl/pcs_sync_fsm.sv
// Receive synchronization FSM: acquires comma alignment, tracks even/odd
// position, and drops sync after repeated bad code-groups.
module pcs_sync_fsm
   import pcs_sync_fsm_pkg::*;
#(
   parameter int GOOD_CGS_MAX = 3,
   parameter int LOS_CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cg_valid,
   input  logic [9:0]           data_10b,
   input  logic                 is_invalid,
   input  logic                 control,
   input  logic                 signal_detect,
   output logic                 sync_status,
   output logic                 rx_even,
   output logic                 cg_good,
   output logic                 sync_lost,
   output logic [LOS_CNT_W-1:0] los_count,
   output logic [3:0]           sync_state
);

   localparam int GC_W = $clog2(GOOD_CGS_MAX + 1);
   localparam logic [GC_W-1:0] GC_LAST = GC_W'(GOOD_CGS_MAX - 1);

   sync_state_e          state_q, state_d;
   logic                 rx_even_q, rx_even_d;
   logic [GC_W-1:0]      good_cgs_q, good_cgs_d;
   logic                 cg_good_q, cg_good_d;
   logic                 sync_lost_q, sync_lost_d;
   logic [LOS_CNT_W-1:0] los_count_q, los_count_d;

   logic comma, cgbad, cggood, cgdata;
   logic loss;

   pcs_sync_fsm_comma_det u_comma_det (
      .data_10b   (data_10b),
      .is_invalid (is_invalid),
      .control    (control),
      .odd_pos    (rx_even_q),
      .comma      (comma),
      .cgbad      (cgbad),
      .cggood     (cggood),
      .cgdata     (cgdata)
   );

   always_comb begin
      state_d     = state_q;
      rx_even_d   = rx_even_q;
      good_cgs_d  = good_cgs_q;
      cg_good_d   = cg_good_q;
      sync_lost_d = 1'b0;
      los_count_d = los_count_q;
      loss        = 1'b0;
      if (!signal_detect) begin
         state_d    = LOSS_OF_SYNC;
         good_cgs_d = '0;
         cg_good_d  = 1'b0;
      end else if (cg_valid) begin
         rx_even_d = ~rx_even_q;
         cg_good_d = is_synced(state_q) & cggood;
         case (state_q)
            LOSS_OF_SYNC:   if (comma & ~is_invalid) state_d = COMMA_DETECT_1;
            COMMA_DETECT_1: state_d = cgdata ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
            COMMA_DETECT_2: state_d = cgdata ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
            COMMA_DETECT_3: state_d = cgdata ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1: begin
               if (cgbad) state_d = LOSS_OF_SYNC;
               else if (comma & ~rx_even_q) state_d = COMMA_DETECT_2;
            end
            ACQUIRE_SYNC_2: begin
               if (cgbad) state_d = LOSS_OF_SYNC;
               else if (comma & ~rx_even_q) state_d = COMMA_DETECT_3;
            end
            SYNC_ACQUIRED_1: begin
               if (cgbad) begin
                  state_d    = SYNC_ACQUIRED_2;
                  good_cgs_d = '0;
               end
            end
            SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
               good_cgs_d = cggood ? GC_W'(1) : '0;
               if (cggood) begin
                  state_d = (state_q == SYNC_ACQUIRED_2) ? SYNC_ACQUIRED_2A :
                            (state_q == SYNC_ACQUIRED_3) ? SYNC_ACQUIRED_3A : SYNC_ACQUIRED_4A;
               end else if (state_q == SYNC_ACQUIRED_4) loss = 1'b1;
               else state_d = (state_q == SYNC_ACQUIRED_2) ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_4;
            end
            SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
               if (cgbad) begin
                  good_cgs_d = '0;
                  if (state_q == SYNC_ACQUIRED_4A) loss = 1'b1;
                  else state_d = (state_q == SYNC_ACQUIRED_2A) ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_4;
               end else if (good_cgs_q == GC_LAST) begin
                  good_cgs_d = '0;
                  state_d = (state_q == SYNC_ACQUIRED_2A) ? SYNC_ACQUIRED_1 :
                            (state_q == SYNC_ACQUIRED_3A) ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_3;
               end else begin
                  good_cgs_d = good_cgs_q + GC_W'(1);
               end
            end
            default: state_d = LOSS_OF_SYNC;
         endcase
         // A fresh comma always defines an even position.
         if (state_d == COMMA_DETECT_1 || state_d == COMMA_DETECT_2 || state_d == COMMA_DETECT_3)
            rx_even_d = 1'b1;
         if (loss) begin
            state_d     = LOSS_OF_SYNC;
            sync_lost_d = 1'b1;
            if (los_count_q != {LOS_CNT_W{1'b1}}) los_count_d = los_count_q + LOS_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= LOSS_OF_SYNC;
         rx_even_q   <= 1'b0;
         good_cgs_q  <= '0;
         cg_good_q   <= 1'b0;
         sync_lost_q <= 1'b0;
         los_count_q <= '0;
      end else begin
         state_q     <= state_d;
         rx_even_q   <= rx_even_d;
         good_cgs_q  <= good_cgs_d;
         cg_good_q   <= cg_good_d;
         sync_lost_q <= sync_lost_d;
         los_count_q <= los_count_d;
      end
   end

   assign sync_status = is_synced(state_q);
   assign rx_even     = rx_even_q;
   assign cg_good     = cg_good_q;
   assign sync_lost   = sync_lost_q;
   assign los_count   = los_count_q;
   assign sync_state  = state_q;

endmodule
